// File: rtl/ifmap_pkg.sv
// Shared types and defaults for the ifmap row-buffer controller.
package ifmap_pkg;

  localparam int DEF_NUM_ROWS  = 4;
  localparam int DEF_ROW_WORDS = 4;
  localparam int DEF_K         = 3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_LAST = 2'd2
  } rd_state_e;

  // Circular increment; both operands must already be below n.
  function automatic logic [31:0] mod_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] n);
    logic [31:0] s;
    s = a + b;
    if (s >= n) begin
      return s - n;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/ifmap_row_ctrl_if.sv
// Writer and window-reader handshake bundle of the ifmap row-buffer controller.
interface ifmap_row_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_start;
  logic                  rd_release;
  logic                  rd_busy;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_done;

  modport master (
    output wr_valid, wr_data, rd_start, rd_release,
    input  wr_ready, rd_busy, rd_valid, rd_data, rd_done
  );

  modport slave (
    input  wr_valid, wr_data, rd_start, rd_release,
    output wr_ready, rd_busy, rd_valid, rd_data, rd_done
  );

endinterface

// File: rtl/row_addr_gen.sv
// Maps a (row slot, word) pair onto the flat RAM address space.
module row_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_WORDS  = 4,
  parameter int SLOT_W     = 2,
  parameter int WORD_W     = 2
) (
  input  logic [SLOT_W-1:0]     slot,
  input  logic [WORD_W-1:0]     word,
  output logic [ADDR_WIDTH-1:0] addr
);

  assign addr = ADDR_WIDTH'(slot) * ADDR_WIDTH'(ROW_WORDS) + ADDR_WIDTH'(word);

endmodule

// File: rtl/ifmap_row_ctrl.sv
// Circular row buffer over a dual-port RAM: port A fills rows, port B
// streams K-row windows starting at the oldest held row.
module ifmap_row_ctrl
  import ifmap_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int ROW_WORDS  = DEF_ROW_WORDS,
  parameter int K          = DEF_K
) (
  input  logic                           clk,
  input  logic                           rst_n,
  ifmap_row_ctrl_if.slave                bus,
  output logic [$clog2(NUM_ROWS+1)-1:0]  row_count,
  output logic [ADDR_WIDTH-1:0]          ram_addr_a,
  output logic [DATA_WIDTH-1:0]          ram_data_a,
  output logic                           ram_we_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_b,
  output logic                           ram_we_b,
  input  logic [DATA_WIDTH-1:0]          ram_q_b
);

  localparam int SLOT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int WORD_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int ROFF_W = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W  = $clog2(NUM_ROWS + 1);

  rd_state_e         state_r, state_s;
  logic [SLOT_W-1:0] wr_slot_r, head_r, rd_slot_s;
  logic [WORD_W-1:0] wr_word_r, rd_word_r;
  logic [ROFF_W-1:0] rd_roff_r;
  logic [CNT_W-1:0]  row_count_r;
  logic              release_r, active_r, rd_valid_r, rd_done_r;
  logic              wr_ready_s, wr_fire_s, row_done_s, release_now_s;
  logic              issue_s, last_addr_s;

  // A release frees the head slot at the LAST->IDLE edge, so a writer
  // blocked on a full buffer may complete a word in that same cycle.
  assign release_now_s = (state_r == RD_LAST) && release_r;
  assign wr_ready_s    = active_r && ((row_count_r < CNT_W'(NUM_ROWS)) || release_now_s);
  assign wr_fire_s     = bus.wr_valid && wr_ready_s;
  assign row_done_s    = wr_fire_s && (wr_word_r == WORD_W'(ROW_WORDS - 1));
  assign last_addr_s   = (rd_roff_r == ROFF_W'(K - 1)) && (rd_word_r == WORD_W'(ROW_WORDS - 1));
  assign rd_slot_s     = SLOT_W'(mod_add(32'(head_r), 32'(rd_roff_r), 32'(NUM_ROWS)));

  // Read FSM next-state and address-issue strobe
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      RD_IDLE: begin
        if (bus.rd_start && (32'(row_count_r) >= 32'(K))) begin
          state_s = RD_READ;
        end else begin
          state_s = RD_IDLE;
        end
      end
      RD_READ: begin
        issue_s = 1'b1;
        if (last_addr_s) begin
          state_s = RD_LAST;
        end else begin
          state_s = RD_READ;
        end
      end
      RD_LAST: state_s = RD_IDLE;
      default: state_s = RD_IDLE;
    endcase
  end

  // Read FSM state, window cursor, latched release and read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RD_IDLE;
      rd_word_r  <= '0;
      rd_roff_r  <= '0;
      release_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_valid_r <= issue_s;
      rd_done_r  <= (state_r == RD_LAST);
      if ((state_r == RD_IDLE) && (state_s == RD_READ)) begin
        release_r <= bus.rd_release;
      end else if (state_r == RD_LAST) begin
        release_r <= 1'b0;
      end
      if (issue_s) begin
        if (rd_word_r == WORD_W'(ROW_WORDS - 1)) begin
          rd_word_r <= '0;
          rd_roff_r <= last_addr_s ? ROFF_W'(0) : rd_roff_r + ROFF_W'(1);
        end else begin
          rd_word_r <= rd_word_r + WORD_W'(1);
        end
      end
    end
  end

  // Write cursor, head pointer and complete-row occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r    <= 1'b0;
      wr_slot_r   <= '0;
      wr_word_r   <= '0;
      head_r      <= '0;
      row_count_r <= '0;
    end else begin
      active_r <= 1'b1;
      if (wr_fire_s) begin
        if (row_done_s) begin
          wr_word_r <= '0;
          wr_slot_r <= SLOT_W'(mod_add(32'(wr_slot_r), 32'd1, 32'(NUM_ROWS)));
        end else begin
          wr_word_r <= wr_word_r + WORD_W'(1);
        end
      end
      if (release_now_s) begin
        head_r <= SLOT_W'(mod_add(32'(head_r), 32'd1, 32'(NUM_ROWS)));
      end
      case ({row_done_s, release_now_s})
        2'b10:   row_count_r <= row_count_r + CNT_W'(1);
        2'b01:   row_count_r <= row_count_r - CNT_W'(1);
        default: row_count_r <= row_count_r;
      endcase
    end
  end

  row_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .ROW_WORDS(ROW_WORDS), .SLOT_W(SLOT_W), .WORD_W(WORD_W)
  ) u_addr_a (
    .slot(wr_slot_r), .word(wr_word_r), .addr(ram_addr_a)
  );

  row_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .ROW_WORDS(ROW_WORDS), .SLOT_W(SLOT_W), .WORD_W(WORD_W)
  ) u_addr_b (
    .slot(rd_slot_s), .word(rd_word_r), .addr(ram_addr_b)
  );

  assign ram_we_a     = wr_fire_s;
  assign ram_data_a   = wr_fire_s ? bus.wr_data : '0;
  assign ram_we_b     = 1'b0;
  assign row_count    = row_count_r;
  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_busy  = (state_r != RD_IDLE);
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_valid_r ? ram_q_b : '0;
  assign bus.rd_done  = rd_done_r;

endmodule

// File: tb/tb_ifmap_row_ctrl.sv
// Directed scoreboard bench for ifmap_row_ctrl (NUM_ROWS=4, ROW_WORDS=4, K=3).
module tb_ifmap_row_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] row_count;
  logic [7:0] ram_addr_a, ram_data_a, ram_addr_b, ram_q_b;
  logic       ram_we_a, ram_we_b;
  logic [7:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;
  int n_vld = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];
  logic       done_wr_ready;
  logic [2:0] done_rc;

  ifmap_row_ctrl_if #(.DATA_WIDTH(8)) bus ();

  ifmap_row_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_ROWS(4), .ROW_WORDS(4), .K(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .row_count(row_count),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // Dual-port RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: every rd_valid word is popped from the scoreboard and compared
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.rd_valid === 1'b1) begin
        n_vld++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_data_unexpected got %0d expected none", bus.rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            n_err++;
            $display("FAIL rd_data got %0d expected %0d", bus.rd_data, e);
          end
        end
      end
      if (bus.rd_done === 1'b1) n_done++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int d);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'(d);
    while (!ok && t < 64) begin
      @(negedge clk);
      ok = bus.wr_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.wr_valid = 1'b0;
    if (!ok) chk("wr_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr_words(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) wr_word(first + i);
  endtask

  // Pushes the expected window (three rows, four words each) then pulses rd_start
  task automatic rd_window(input bit rel, input int r0, input int r1, input int r2);
    int rows[3];
    rows = '{r0, r1, r2};
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < 4; w++) exp_q.push_back(8'(rows[r] + w));
    bus.rd_start   = 1'b1;
    bus.rd_release = rel;
    @(posedge clk);
    #1;
    bus.rd_start   = 1'b0;
    bus.rd_release = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    int t;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 64) begin
      @(negedge clk);
      if (bus.rd_done === 1'b1) begin
        seen = 1'b1;
        done_wr_ready = bus.wr_ready;
        done_rc = row_count;
      end
      t++;
    end
    chk("rd_done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic full_read(input string nm, input bit rel, input int r0, input int r1,
                           input int r2, input int rc_after);
    int d0, v0;
    d0 = n_done;
    v0 = n_vld;
    rd_window(rel, r0, r1, r2);
    wait_done();
    chk({nm, "_rd_done_count"}, n_done - d0, 32'd1);
    chk({nm, "_rd_valid_count"}, n_vld - v0, 32'd12);
    chk({nm, "_row_count"}, done_rc, rc_after);
  endtask

  initial begin
    int busy_cnt, v0, d0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'd0;
    bus.rd_start   = 1'b0;
    bus.rd_release = 1'b0;

    // Outputs while reset is held
    @(negedge clk);
    chk("rst_wr_ready", bus.wr_ready, 32'd0);
    chk("rst_rd_busy", bus.rd_busy, 32'd0);
    chk("rst_rd_valid", bus.rd_valid, 32'd0);
    chk("rst_rd_done", bus.rd_done, 32'd0);
    chk("rst_row_count", row_count, 32'd0);
    chk("rst_ram_we_a", ram_we_a, 32'd0);
    chk("rst_ram_we_b", ram_we_b, 32'd0);
    do_reset();
    @(negedge clk);
    chk("post_rst_wr_ready", bus.wr_ready, 32'd1);
    @(posedge clk);
    #1;

    // Basic window: 12 words then one read without release
    wr_words(0, 12);
    @(negedge clk);
    chk("a_row_count_before", row_count, 32'd3);
    @(posedge clk);
    #1;
    full_read("a", 1'b0, 0, 4, 8, 3);

    // Full buffer, then release frees a slot
    do_reset();
    wr_words(100, 16);
    @(negedge clk);
    chk("b_full_wr_ready", bus.wr_ready, 32'd0);
    chk("b_full_row_count", row_count, 32'd4);
    @(posedge clk);
    #1;
    full_read("b", 1'b1, 100, 104, 108, 3);
    chk("b_wr_ready_at_done", done_wr_ready, 32'd1);

    // Head walks 1 -> 2 -> 3 -> 0, then a window over slots 0,1,2
    wr_words(116, 4);
    full_read("d1", 1'b1, 104, 108, 112, 3);
    wr_words(120, 4);
    full_read("d2", 1'b1, 108, 112, 116, 3);
    wr_words(124, 4);
    full_read("d3_head3", 1'b1, 112, 116, 120, 3);
    full_read("d4_wrapped", 1'b0, 116, 120, 124, 3);

    // Only two rows held: rd_start must be ignored
    do_reset();
    wr_words(50, 8);
    v0 = n_vld;
    d0 = n_done;
    bus.rd_start = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_busy === 1'b1) busy_cnt++;
    end
    @(posedge clk);
    #1;
    chk("c_busy_cycles", busy_cnt, 32'd0);
    chk("c_rd_valid_count", n_vld - v0, 32'd0);
    chk("c_rd_done_count", n_done - d0, 32'd0);
    chk("c_row_count", row_count, 32'd2);

    // Row completion on the same edge as the release
    do_reset();
    wr_words(0, 15);
    rd_window(1'b1, 0, 4, 8);
    repeat (12) @(posedge clk);
    #1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd15;
    @(negedge clk);
    chk("e_busy_in_last", bus.rd_busy, 32'd1);
    chk("e_wr_ready_in_last", bus.wr_ready, 32'd1);
    chk("e_row_count_in_last", row_count, 32'd3);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    wait_done();
    chk("e_row_count_unchanged", done_rc, 32'd3);
    full_read("e_after", 1'b0, 4, 8, 12, 3);

    // Reset in the middle of a window read
    do_reset();
    wr_words(200, 12);
    rd_window(1'b0, 200, 204, 208);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("f_rd_valid", bus.rd_valid, 32'd0);
    chk("f_rd_busy", bus.rd_busy, 32'd0);
    chk("f_rd_done", bus.rd_done, 32'd0);
    chk("f_row_count", row_count, 32'd0);
    exp_q.delete();
    d0 = n_done;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("f_no_rd_done", n_done - d0, 32'd0);
    chk("f_idle_busy", bus.rd_busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
